// File: rtl/conv_pkg.sv
// Shared constants, state encoding and helpers for the conv output path.
package conv_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int IMAGE_SIZE  = 28;
  localparam int KERNEL_SIZE = 5;
  localparam int OUTPUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int FRAME_WORDS = OUTPUT_SIZE * OUTPUT_SIZE;
  localparam int IDX_W       = $clog2(FRAME_WORDS);
  localparam int RC_W        = $clog2(OUTPUT_SIZE);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  // Clamp negative words to zero.
  function automatic logic [WORD_LENGTH-1:0] relu_word(input logic [WORD_LENGTH-1:0] w);
    if (w[WORD_LENGTH-1]) begin
      return {WORD_LENGTH{1'b0}};
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/conv_ser_index_counter.sv
// Flat word index plus row/column coordinates of the serializer.
// Clear has priority over advance; advancing past the last word wraps to 0.
module conv_ser_index_counter
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            advance_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [RC_W-1:0]  row_o,
  output logic [RC_W-1:0]  col_o,
  output logic            last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RC_W-1:0]  row_q, row_d;
  logic [RC_W-1:0]  col_q, col_d;
  logic             last_s;

  assign last_s = (idx_q == IDX_W'(FRAME_WORDS - 1));

  // Next-index logic with column wrap.
  always_comb begin
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    if (clear_i || (advance_i && last_s)) begin
      idx_d = {IDX_W{1'b0}};
      row_d = {RC_W{1'b0}};
      col_d = {RC_W{1'b0}};
    end else if (advance_i) begin
      idx_d = idx_q + IDX_W'(1);
      if (col_q == RC_W'(OUTPUT_SIZE - 1)) begin
        col_d = {RC_W{1'b0}};
        row_d = row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= {IDX_W{1'b0}};
      row_q <= {RC_W{1'b0}};
      col_q <= {RC_W{1'b0}};
    end else begin
      idx_q <= idx_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign idx_o  = idx_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = last_s;

endmodule

// File: rtl/conv_out_serializer.sv
// Replays a captured conv result frame as a valid/ready word stream with coordinates.
// Optional CONV_SER_RELU_EN clamps negative output words to zero.
module conv_out_serializer
  import conv_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [WORD_LENGTH*FRAME_WORDS-1:0] data_in,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [WORD_LENGTH-1:0]             data_out,
  output logic [RC_W-1:0]                    out_row,
  output logic [RC_W-1:0]                    out_col,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overflow
);

  ser_state_e state_q, state_d;
  logic       in_valid_q;
  logic       armed_q;
  logic       overflow_q, overflow_d;
  logic [WORD_LENGTH*FRAME_WORDS-1:0] frame_q;

  logic             start_s, accept_s, capture_s;
  logic [IDX_W-1:0] idx_s;
  logic [RC_W-1:0]  row_s, col_s;
  logic             last_s;
  logic [WORD_LENGTH-1:0] raw_s, word_s;

  // armed_q blocks a frame start until in_valid has been seen low after reset.
  assign start_s  = in_valid && !in_valid_q && armed_q;
  assign accept_s = (state_q == STREAM) && out_ready;

  // Next-state, capture and overflow decisions.
  always_comb begin
    state_d    = state_q;
    capture_s  = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          capture_s = 1'b1;
          state_d   = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (accept_s && last_s) begin
          if (start_s) begin
            capture_s = 1'b1;
            state_d   = STREAM;
          end else begin
            state_d = IDLE;
          end
        end else if (start_s) begin
          overflow_d = 1'b1;
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_valid_q <= 1'b0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= in_valid;
      armed_q    <= armed_q || !in_valid;
      overflow_q <= overflow_d;
    end
  end

  // Frame buffer; contents are meaningless until the first capture.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      frame_q <= data_in;
    end
  end

  conv_ser_index_counter u_index (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (capture_s),
    .advance_i (accept_s),
    .idx_o     (idx_s),
    .row_o     (row_s),
    .col_o     (col_s),
    .last_o    (last_s)
  );

  assign raw_s = frame_q[idx_s*WORD_LENGTH +: WORD_LENGTH];

`ifdef CONV_SER_RELU_EN
  assign word_s = relu_word(raw_s);
`else
  assign word_s = raw_s;
`endif

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign data_out  = out_valid ? word_s : {WORD_LENGTH{1'b0}};
  assign out_last  = out_valid && last_s;
  assign out_row   = row_s;
  assign out_col   = col_s;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_out_serializer.sv
// Randomized bench for conv_out_serializer against a queue-based frame model.
module tb_conv_out_serializer;
  import conv_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               in_valid;
  logic [WORD_LENGTH*FRAME_WORDS-1:0] din;
  logic                               out_ready;
  logic                               out_valid;
  logic [WORD_LENGTH-1:0]             data_out;
  logic [RC_W-1:0]                    out_row;
  logic [RC_W-1:0]                    out_col;
  logic                               out_last;
  logic                               busy;
  logic                               overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  conv_out_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef CONV_SER_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of remaining (word, index) beats of the frame in flight.
  logic [15:0] exp_word[$];
  int          exp_idx[$];
  bit          exp_ovf = 1'b0;
  bit          prev_iv = 1'b1;

  always @(posedge clk) begin
    if (!rst) begin
      exp_word.delete();
      exp_idx.delete();
      exp_ovf = 1'b0;
      prev_iv = 1'b1;
    end else begin
      if (exp_word.size() > 0 && out_ready) begin
        void'(exp_word.pop_front());
        void'(exp_idx.pop_front());
      end
      if (in_valid && !prev_iv) begin
        if (exp_word.size() == 0) begin
          for (int w = 0; w < FRAME_WORDS; w++) begin
            exp_word.push_back(din[16*w +: 16]);
            exp_idx.push_back(w);
          end
        end else begin
          exp_ovf = 1'b1;
        end
      end
      prev_iv = in_valid;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_word.size() > 0));
      chk("busy", 32'(busy), 32'(exp_word.size() > 0));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (exp_word.size() > 0) begin
        chk("data_out", 32'(data_out), 32'(relu(exp_word[0])));
        chk("out_row", 32'(out_row), 32'(exp_idx[0] / OUTPUT_SIZE));
        chk("out_col", 32'(out_col), 32'(exp_idx[0] % OUTPUT_SIZE));
        chk("out_last", 32'(out_last), 32'(exp_idx[0] == FRAME_WORDS - 1));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_ramp();
    for (int w = 0; w < FRAME_WORDS; w++) din[16*w +: 16] = 16'(w);
  endtask

  task automatic fill_rand();
    for (int w = 0; w < FRAME_WORDS; w++) din[16*w +: 16] = 16'($urandom);
  endtask

  // Raise in_valid, let it be sampled, and check the first beat appears next cycle.
  task automatic start_frame(input logic [15:0] first);
    in_valid = 1'b1;
    step();
    chk("start_valid", 32'(out_valid), 32'd1);
    chk("start_data", 32'(data_out), 32'(relu(first)));
    chk("start_row", 32'(out_row), 32'd0);
    chk("start_col", 32'(out_col), 32'd0);
  endtask

  // Drive out_ready and count accepted beats; ev 1 = new frame start, 2 = same as 1
  // (used on the last beat), 3 = reset at ev_beat.
  task automatic stream_frame(input bit rnd_ready, input int hold, input int ev, input int ev_beat,
                              input int lit_beat, input logic [15:0] lit_val,
                              input int lit_row, input int lit_col);
    int beat = 0;
    int cyc  = 0;
    while (beat < FRAME_WORDS && cyc < 5000) begin
      if (cyc >= hold) in_valid = 1'b0;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (beat == lit_beat) begin
          chk("lit_data", 32'(data_out), 32'(lit_val));
          chk("lit_row", 32'(out_row), 32'(lit_row));
          chk("lit_col", 32'(out_col), 32'(lit_col));
        end
        if (beat == FRAME_WORDS - 1) chk("last_beat", 32'(out_last), 32'd1);
        if (ev != 0 && beat == ev_beat) begin
          if (ev == 3) begin
            rst = 1'b0;
            step();
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_row", 32'(out_row), 32'd0);
            chk("rst_col", 32'(out_col), 32'd0);
            chk("rst_data", 32'(data_out), 32'd0);
            rst = 1'b1;
            return;
          end
          fill_rand();
          din[15] = 1'b0;
          in_valid = 1'b1;
        end
        beat++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    if (beat < FRAME_WORDS) chk("stream_timeout", 32'(beat), 32'(FRAME_WORDS));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b0;
    logic [15:0] neg_exp;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    @(negedge clk);
    step(); step();
    chk_en = 1'b1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
    chk("reset_row", 32'(out_row), 32'd0);
    chk("reset_col", 32'(out_col), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();

    // Ramp frame at full throughput.
    fill_ramp();
    start_frame(16'h0000);
    stream_frame(1'b0, 0, 0, -1, 25, 16'd25, 1, 1);
    chk("ramp_busy_fall", 32'(busy), 32'd0);
    step();

    // Random data under random backpressure.
    fill_rand();
    start_frame(din[15:0]);
    stream_frame(1'b1, 0, 0, -1, -1, 16'h0, 0, 0);
    step(); step();

    // Overflow: second start at beat 100 is dropped.
    fill_ramp();
    start_frame(16'h0000);
    stream_frame(1'b0, 0, 1, 100, 300, 16'd300, 12, 12);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(); step(); step();
    chk("ovf_dropped", 32'(busy), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b0;
    step();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    rst = 1'b1;
    step();

    // Back-to-back: new start on the cycle the last beat is accepted.
    fill_ramp();
    start_frame(16'h0000);
    stream_frame(1'b0, 0, 2, FRAME_WORDS - 1, -1, 16'h0, 0, 0);
    b0 = din[15:0];
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_data", 32'(data_out), 32'(b0));
    chk("b2b_row", 32'(out_row), 32'd0);
    chk("b2b_col", 32'(out_col), 32'd0);
    stream_frame(1'b1, 0, 0, -1, -1, 16'h0, 0, 0);
    chk("b2b_no_ovf", 32'(overflow), 32'd0);
    step();

    // Reset in the middle of a frame, then a fresh frame.
    fill_ramp();
    start_frame(16'h0000);
    stream_frame(1'b0, 0, 3, 300, -1, 16'h0, 0, 0);
    step();
    fill_rand();
    start_frame(din[15:0]);
    stream_frame(1'b0, 0, 0, -1, 0, din[15:0], 0, 0);
    step();

    // Negative word at element 5, in_valid held high for 10 cycles.
    fill_rand();
    din[15] = 1'b0;
    din[16*5 +: 16] = 16'hFFF2;
`ifdef CONV_SER_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFF2;
`endif
    start_frame(din[15:0]);
    stream_frame(1'b0, 9, 0, -1, 5, neg_exp, 0, 5);
    step(); step(); step();
    chk("hold_one_frame", 32'(busy), 32'd0);
    chk("hold_no_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_out_serializer.md
# conv_out_serializer

Receives the wide, flat result bus of the `conv` core (24×24 outputs × 16 bits, qualified by `out_valid`) and replays it as a word-serial stream with a valid/ready handshake. Each frame is emitted one output per beat, with its row/column coordinates and an end-of-frame flag. The block sits directly downstream of `conv`, replacing the parallel golden-compare path with a stream that narrow consumers (DMA, pooling, checker) can accept.

## Interface
- `WORD_LENGTH`, 16: width of one output word (the `conv` double word).
- `OUTPUT_SIZE`, 24: output feature side length (image 28 − kernel 5 + 1).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset is synchronous and active-low; `rst`=0 sampled on a rising edge of `clk` resets the block.
- `in_valid` input 1: connected to `conv` `out_valid`; a rising edge marks a new frame on `data_in`.
- `data_in` input WORD_LENGTH·OUTPUT_SIZE²: flat frame; element w = row·OUTPUT_SIZE+col at bits [WORD_LENGTH·w +: WORD_LENGTH].
- `out_ready` input 1: consumer accepts the current beat.
- `out_valid` output 1: `data_out` and sideband hold a valid beat.
- `data_out` output WORD_LENGTH: current output word, signed.
- `out_row` output clog2(OUTPUT_SIZE): row of current word.
- `out_col` output clog2(OUTPUT_SIZE): column of current word.
- `out_last` output 1: high on the beat for w = OUTPUT_SIZE²−1.
- `busy` output 1: high while in STREAM.
- `overflow` output 1: sticky; a frame arrived while the previous one was still streaming and was dropped.

## Operation
- Frame start is the rising edge of `in_valid`, detected against a registered copy `in_valid_d`. If `in_valid` stays high, that counts as one frame only.
- IDLE: on a frame start, capture the whole `data_in` into the frame buffer, clear idx/row/col to 0, then go to STREAM.
- STREAM: `out_valid`=1 and `data_out`=buf[idx]. A beat is accepted when `out_valid && out_ready`. On each accept:
  - idx increments.
  - col increments; when col reaches OUTPUT_SIZE−1 it wraps to 0 and row increments.
- Last beat accepted (idx = OUTPUT_SIZE²−1):
  - With a frame start in the same cycle: capture the new frame, reset the counters, and stay in STREAM (back-to-back frames).
  - Otherwise: return to IDLE.
- Frame start in STREAM at any other time: the new frame is dropped, `overflow` is set, and the current stream continues undisturbed.
- `out_row`, `out_col`, `out_last` and `data_out` are derived only from registered state.
- Buffer contents are not cleared by reset; they are don't-care until the next capture.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `overflow`=0, `out_last`=0, `out_row`=0, `out_col`=0, `data_out`=0. State=IDLE, `in_valid_d`=0.
- Latency: a frame start sampled at edge N gives `out_valid`=1 with element 0 after edge N (i.e. during cycle N+1).
- Throughput: 1 word per cycle with `out_ready` held high. A frame takes OUTPUT_SIZE² = 576 cycles.
- Handshake rules:
  - Once `out_valid` is raised, it and all outputs stay stable until accepted.
  - `out_valid` never depends combinationally on `out_ready`.
- Reset mid-stream: on the next edge the block is in IDLE with all outputs at their reset values. The partial frame is discarded. A frame start needs `in_valid` seen low after reset.
- `overflow` clears only on reset.

## Configuration
- `CONV_SER_RELU_EN` defined: `data_out` is forced to 0 whenever buf[idx] is negative (MSB=1). The captured buffer is unchanged, and coordinates and handshake are unaffected.
- `CONV_SER_RELU_EN` undefined: `data_out` is the raw signed word.

## Structure
- Shared package `conv_pkg` holds:
  - WORD_LENGTH, IMAGE_SIZE=28, KERNEL_SIZE=5, OUTPUT_SIZE.
  - Derived widths IDX_W=clog2(OUTPUT_SIZE²)=10 and RC_W=clog2(OUTPUT_SIZE)=5.
  - The state enum {IDLE, STREAM}.
- One sub-module, `conv_ser_index_counter`, holds idx/row/col with the wrap logic, clear and advance inputs, and a `last` output. Everything else lives in the top level.

## Test plan
- Ramp frame (element w = w): one `in_valid` pulse with `out_ready`=1 → 576 beats. `data_out` 0..575 in order; beat 25 shows row=1, col=1; `out_last` only on beat 575; `busy` falls the next cycle.
- Backpressure: toggle `out_ready` pseudo-randomly → no beat lost or duplicated; outputs stay stable during every stall; sequence still 0..575.
- Overflow: second frame start at beat 100 → first frame completes intact, second is dropped, `overflow`=1 until reset.
- Back-to-back: second frame start in the same cycle the last beat is accepted → beat 576 is element 0 of frame 2; no gap; `overflow`=0.
- Reset at beat 300 → the next cycle shows `out_valid`=0, row=col=0. A new frame then streams from element 0.
- Negative data with element 5 = 16'hFFF2 → `data_out`=16'h0000 with `CONV_SER_RELU_EN` defined, 16'hFFF2 without; `in_valid` held high 10 cycles yields exactly one frame.
